mul4su_rr_sched: RTL and testbench

//   Shares one exact 4x4 signed x unsigned multiplier core (RM4su10) among NREQ requesters.

---
 rtl/mul4su_rr_sched_pkg.sv | 28 ++
 rtl/mul4su_rr_sched_if.sv | 28 ++
 rtl/mul4su_rr_sched_arb.sv | 23 ++
 rtl/mul4su_rr_sched_core.sv | 23 ++
 rtl/mul4su_rr_sched.sv | 75 +++++++
 tb/tb_mul4su_rr_sched.sv | 191 +++++++++++++++++++
 6 files changed

// File: rtl/mul4su_rr_sched_pkg.sv
// Shared types and helpers for the shared 4x4 signed x unsigned multiplier scheduler.
package mul4su_pkg;
    localparam int OPW      = 4;
    localparam int PRODW    = 8;
    localparam int NREQ_MAX = 8;

    typedef logic [OPW-1:0]          op_t;
    typedef logic signed [PRODW-1:0] prod_t;

    // Lanes above the real lane count are passed in as zero, so wrapping modulo
    // NREQ_MAX gives the same search order as wrapping modulo the real count.
    function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                           input logic [2:0]          ptr);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = ptr + 3'(k);
            if (!found && valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction
endpackage

// File: rtl/mul4su_rr_sched_if.sv
// Requester / response bundle between the PE lanes and the shared multiplier scheduler.
interface mul4su_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
);
    import mul4su_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][OPW-1:0] req_s;
    logic [NREQ-1:0][OPW-1:0] req_u;
    logic                     rsp_valid;
    logic                     rsp_ready;
    prod_t                    rsp_prod;
    logic [IDW-1:0]           rsp_id;
    logic [CNTW-1:0]          op_cnt;

    modport master (
        output req_valid, req_s, req_u, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod, rsp_id, op_cnt
    );

    modport slave (
        input  req_valid, req_s, req_u, rsp_ready,
        output req_ready, rsp_valid, rsp_prod, rsp_id, op_cnt
    );
endinterface

// File: rtl/mul4su_rr_sched_arb.sv
// rr_arb_n: combinational round-robin picker, one-hot grant starting the search at ptr.
module rr_arb_n
    import mul4su_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)(
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_any
);
    logic [NREQ_MAX-1:0] w_req_pad;
    logic [2:0]          w_win;

    assign w_req_pad = NREQ_MAX'(i_req);
    assign w_win     = rr_pick(w_req_pad, 3'(i_ptr));
    assign o_gnt_id  = IDW'(w_win);
    assign o_any     = |i_req;
    assign o_gnt     = (i_en && o_any) ? (NREQ'(1) << o_gnt_id) : '0;
endmodule

// File: rtl/mul4su_rr_sched_core.sv
// RM4su10: exact 4x4 signed x unsigned multiplier, shift-add over the unsigned operand.
module RM4su10
    import mul4su_pkg::*;
(
    input  op_t   i_s,
    input  op_t   i_u,
    output prod_t o_prod
);
    logic [PRODW-1:0] w_s_ext;
    logic [PRODW-1:0] w_acc;

    assign w_s_ext = {{(PRODW-OPW){i_s[OPW-1]}}, i_s};

    // Modulo-256 accumulation is exact because the true product fits in 8 signed bits.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < OPW; i++) begin
            if (i_u[i]) w_acc = w_acc + (w_s_ext << i);
        end
    end

    assign o_prod = $signed(w_acc);
endmodule

// File: rtl/mul4su_rr_sched.sv
// Shares one RM4su10 among NREQ requesters; round-robin grant into a single response slot.
module mul4su_rr_sched
    import mul4su_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
)(
    input logic                clk,
    input logic                rst,
    mul4su_rr_sched_if.slave   bus
);
    logic            r_rsp_valid;
    prod_t           r_rsp_prod;
    logic [IDW-1:0]  r_rsp_id;
    logic [CNTW-1:0] r_op_cnt;
    logic [IDW-1:0]  r_rr_ptr;

    logic            w_slot_free;
    logic            w_en;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_any;
    logic            w_accept;
    op_t             w_s;
    op_t             w_u;
    prod_t           w_prod;

    // Grants are masked during reset so no lane sees a handshake that gets discarded.
    assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
    assign w_en        = w_slot_free && !rst;

    rr_arb_n #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req    (bus.req_valid),
        .i_ptr    (r_rr_ptr),
        .i_en     (w_en),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    assign w_accept = w_any && w_en;
    assign w_s      = bus.req_s[w_gnt_id];
    assign w_u      = bus.req_u[w_gnt_id];

    RM4su10 u_core (
        .i_s    (w_s),
        .i_u    (w_u),
        .o_prod (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_prod  <= '0;
            r_rsp_id    <= '0;
            r_op_cnt    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_prod  <= w_prod;
            r_rsp_id    <= w_gnt_id;
            r_op_cnt    <= r_op_cnt + CNTW'(1);
            r_rr_ptr    <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_prod  = r_rsp_prod;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.op_cnt    = r_op_cnt;
endmodule

// File: tb/tb_mul4su_rr_sched.sv
// Directed and randomized bench for mul4su_rr_sched against a cycle-level behavioural model.
module tb_mul4su_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul4su_rr_sched_if #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus();

    mul4su_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_ptr;
    logic       m_vld;
    logic [7:0] m_prod;
    int         m_id;
    int         m_cnt;
    int         m_acc;
    logic [3:0] obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_prod(input logic [3:0] s, input logic [3:0] u);
        int sv;
        sv = int'(s);
        if (sv > 7) sv = sv - 16;
        return 8'(sv * int'(u));
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: apply inputs at the falling edge, check grant, advance model, check outputs.
    task automatic cycle(input logic [3:0] vld, input logic rr, input logic rs);
        int         win;
        logic       free;
        logic [3:0] exp_rdy;
        bus.req_valid = vld;
        bus.rsp_ready = rr;
        rst           = rs;
        #1;
        free    = !m_vld || rr;
        win     = pick(vld, m_ptr);
        exp_rdy = (!rs && free && win >= 0) ? 4'(1 << win) : 4'b0;
        obs_rdy = bus.req_ready;
        chk("req_ready", 32'(obs_rdy), 32'(exp_rdy));
        m_acc = -1;
        @(posedge clk);
        if (rs) begin
            m_vld = 1'b0; m_prod = '0; m_id = 0; m_cnt = 0; m_ptr = 0;
        end else if (exp_rdy != 4'b0) begin
            m_acc  = win;
            m_prod = ref_prod(bus.req_s[win], bus.req_u[win]);
            m_id   = win;
            m_vld  = 1'b1;
            m_ptr  = (win + 1) % NREQ;
            m_cnt  = (m_cnt + 1) % (1 << CNTW);
        end else if (rr) begin
            m_vld = 1'b0;
        end
        #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
        chk("rsp_prod", {24'h0, bus.rsp_prod}, {24'h0, m_prod});
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("op_cnt", 32'(bus.op_cnt), 32'(m_cnt));
        @(negedge clk);
    endtask

    logic [7:0] pairs[$];
    logic [3:0] lv;
    int         waitc[NREQ];
    int         next_p, done, acc_total;

    initial begin
        m_ptr = 0; m_vld = 1'b0; m_prod = '0; m_id = 0; m_cnt = 0; m_acc = -1;
        bus.req_valid = '0; bus.req_s = '0; bus.req_u = '0; bus.rsp_ready = 1'b0;
        @(negedge clk);

        // reset state
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);
        chk("rst_ready", 32'(obs_rdy), 32'h0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
        cycle(4'b0000, 1'b1, 1'b0);

        // single lane, most negative product
        bus.req_s[0] = 4'b1000; bus.req_u[0] = 4'd15;
        cycle(4'b0001, 1'b1, 1'b0);
        chk("t1_ready", 32'(obs_rdy), 32'h1);
        chk("t1_prod", {24'h0, bus.rsp_prod}, 32'h88);
        chk("t1_id", 32'(bus.rsp_id), 32'h0);
        cycle(4'b0000, 1'b1, 1'b0);

        // all lanes valid: strict rotation
        cycle(4'b0000, 1'b0, 1'b1);
        for (int l = 0; l < NREQ; l++) begin
            bus.req_s[l] = 4'($urandom_range(15, 0));
            bus.req_u[l] = 4'($urandom_range(15, 0));
        end
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            chk("t2_order", 32'(bus.rsp_id), 32'(k % NREQ));
        end
        chk("t2_cnt", 32'(bus.op_cnt), 32'd5);
        cycle(4'b0000, 1'b1, 1'b0);

        // backpressure holds the slot
        bus.req_s[2] = 4'd7; bus.req_u[2] = 4'd15;
        cycle(4'b0100, 1'b1, 1'b0);
        chk("t3_prod", {24'h0, bus.rsp_prod}, 32'h69);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0100, 1'b0, 1'b0);
            chk("t3_bp_ready", 32'(obs_rdy), 32'h0);
            chk("t3_bp_prod", {24'h0, bus.rsp_prod}, 32'h69);
            chk("t3_bp_id", 32'(bus.rsp_id), 32'h2);
        end
        cycle(4'b0100, 1'b1, 1'b0);
        chk("t3_resume", 32'(obs_rdy), 32'h4);

        // drain and refill in one cycle
        bus.req_s[1] = 4'hF; bus.req_u[1] = 4'd1;
        cycle(4'b0010, 1'b1, 1'b0);
        chk("t4_ready", 32'(obs_rdy), 32'h2);
        chk("t4_prod", {24'h0, bus.rsp_prod}, 32'hFF);
        chk("t4_valid", 32'(bus.rsp_valid), 32'h1);
        cycle(4'b0000, 1'b1, 1'b0);

        // reset with a pending response
        cycle(4'b0000, 1'b0, 1'b1);
        bus.req_s[3] = 4'd3; bus.req_u[3] = 4'd5;
        cycle(4'b1000, 1'b0, 1'b0);
        chk("t5_prod", {24'h0, bus.rsp_prod}, 32'h0F);
        cycle(4'b1000, 1'b1, 1'b1);
        chk("t5_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("t5_rst_cnt", 32'(bus.op_cnt), 32'h0);
        cycle(4'b1001, 1'b1, 1'b0);
        chk("t5_lane0_first", 32'(obs_rdy), 32'h1);
        cycle(4'b1000, 1'b1, 1'b0);
        chk("t5_lane3_next", 32'(bus.rsp_id), 32'h3);

        // randomized: every (s,u) pair on random lanes with random backpressure
        cycle(4'b0000, 1'b0, 1'b1);
        for (int p = 0; p < 256; p++) pairs.push_back(8'(p));
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] t;
            j = $urandom_range(i, 0);
            t = pairs[i]; pairs[i] = pairs[j]; pairs[j] = t;
        end
        lv = '0; next_p = 0; done = 0; acc_total = 0;
        for (int l = 0; l < NREQ; l++) waitc[l] = 0;
        for (int c = 0; c < 4000 && done < 256; c++) begin
            for (int l = 0; l < NREQ; l++) begin
                if (!lv[l] && next_p < 256 && $urandom_range(3, 0) != 0) begin
                    bus.req_s[l] = pairs[next_p][7:4];
                    bus.req_u[l] = pairs[next_p][3:0];
                    lv[l] = 1'b1; waitc[l] = 0; next_p++;
                end
            end
            cycle(lv, 1'($urandom_range(3, 0) != 0), 1'b0);
            if (m_acc >= 0) begin
                chk("fairness", 32'(waitc[m_acc] < NREQ), 32'h1);
                lv[m_acc] = 1'b0; done++; acc_total++;
                for (int l = 0; l < NREQ; l++) if (lv[l]) waitc[l]++;
            end
        end
        chk("rand_all_done", 32'(done), 32'd256);
        chk("rand_op_cnt", 32'(bus.op_cnt), 32'(acc_total));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
